// File: rtl/disp_regctrl.sv
// Display register block and raster timing generator: holds the frame-buffer base
// and control/interrupt/FIFO registers, and produces HSYNC/VSYNC/DE for the pixel reader.
module disp_regctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic [15:0] WRADDR,
  input  logic [3:0]  BYTEEN,
  input  logic        WREN,
  input  logic [31:0] WDATA,
  input  logic [15:0] RDADDR,
  input  logic        RDEN,
  output logic [31:0] RDATA,
  input  logic        FIFO_UNDER,
  output logic        DSP_HSYNC,
  output logic        DSP_VSYNC,
  output logic        DSP_DE,
  output logic        FRAME_START,
  output logic [28:0] DSP_ADDR,
  output logic        DSP_ON,
  output logic        DISP_IRQ
);

  localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [28:2]   disp_addr;
  logic [28:2]   dsp_addr;
  logic          disp_on;
  logic          vblank;
  logic          int_en;
  logic          irq;
  logic          under;
  logic          run;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  logic          wr_addr, wr_ctrl, wr_int, wr_fifo;
  logic          frame_end, vblank_evt, start;
  logic [31:0]   rd_mux;
  logic          unused_wdata;

  assign unused_wdata = ^WDATA[31:29];

  assign wr_addr    = WREN && (WRADDR == 16'h2000);
  assign wr_ctrl    = WREN && (WRADDR == 16'h2004) && BYTEEN[0];
  assign wr_int     = WREN && (WRADDR == 16'h2008) && BYTEEN[0];
  assign wr_fifo    = WREN && (WRADDR == 16'h200C) && BYTEEN[0];
  assign frame_end  = (hcnt == H_LAST) && (vcnt == V_LAST);
  assign vblank_evt = run && (hcnt == '0) && (vcnt == V_ACT);
  assign start      = !run && disp_on;

  assign DSP_ADDR = {dsp_addr, 2'b00};
  assign DSP_ON   = run;
  assign DISP_IRQ = irq;

  always_comb begin
    rd_mux = 32'hDEADFACE;
    case (RDADDR)
      16'h2000: rd_mux = {3'b000, disp_addr, 2'b00};
      16'h2004: rd_mux = {30'd0, vblank, disp_on};
      16'h2008: rd_mux = {30'd0, irq, int_en};
      16'h200C: rd_mux = {31'd0, under};
      default:  rd_mux = 32'hDEADFACE;
    endcase
  end

  // Hardware set events take priority over software write-1-to-clear.
  always_ff @(posedge ACLK) begin
    if (!ARST) begin
      disp_addr <= '0;
      dsp_addr  <= '0;
      disp_on   <= 1'b0;
      vblank    <= 1'b0;
      int_en    <= 1'b0;
      irq       <= 1'b0;
      under     <= 1'b0;
      RDATA     <= '0;
    end else begin
      if (wr_addr) begin
        if (BYTEEN[0]) disp_addr[7:2]   <= WDATA[7:2];
        if (BYTEEN[1]) disp_addr[15:8]  <= WDATA[15:8];
        if (BYTEEN[2]) disp_addr[23:16] <= WDATA[23:16];
        if (BYTEEN[3]) disp_addr[28:24] <= WDATA[28:24];
      end
      if (wr_ctrl) disp_on <= WDATA[0];
      if (wr_int)  int_en  <= WDATA[0];

      if (vblank_evt)                vblank <= 1'b1;
      else if (wr_ctrl && WDATA[1])  vblank <= 1'b0;

      if (vblank_evt && int_en)      irq <= 1'b1;
      else if (wr_int && WDATA[1])   irq <= 1'b0;

      if (FIFO_UNDER)                under <= 1'b1;
      else if (wr_fifo && WDATA[0])  under <= 1'b0;

      if (start || vblank_evt) dsp_addr <= disp_addr;
      if (RDEN) RDATA <= rd_mux;
    end
  end

  // Stopping waits for the last pixel of the frame so frames are never cut short.
  always_ff @(posedge ACLK) begin
    if (!ARST) begin
      run  <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (!run) run <= disp_on;
      else if (frame_end && !disp_on) run <= 1'b0;

      if (!run) begin
        hcnt <= '0;
        vcnt <= '0;
      end else if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARST) begin
      DSP_HSYNC   <= 1'b1;
      DSP_VSYNC   <= 1'b1;
      DSP_DE      <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      DSP_DE      <= run && (hcnt < H_ACT) && (vcnt < V_ACT);
      DSP_HSYNC   <= !(run && (hcnt >= HS_BEG) && (hcnt < HS_END));
      DSP_VSYNC   <= !(run && (vcnt >= VS_BEG) && (vcnt < VS_END));
      FRAME_START <= run && (hcnt == '0) && (vcnt == '0);
    end
  end

endmodule

// File: doc/disp_regctrl.md
Name: disp_regctrl

Overview:
- Display-side counterpart of the capture register block.
- Holds the display frame-buffer base address and control, interrupt and FIFO registers on the 16-bit-address register bus.
- Generates the raster timing (HSYNC/VSYNC/DE) that paces the frame-buffer reader and its pixel FIFO.
- Latches the frame base at vertical blank and raises a vblank interrupt so software can page-flip.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, HSYNC pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- ACLK  in  1  system/pixel clock
- ARST  in  1  synchronous reset, active-low (0 = reset)
- WRADDR  in  16  register write address
- BYTEEN  in  4  write byte enables
- WREN  in  1  write strobe
- WDATA  in  32  write data
- RDADDR  in  16  register read address
- RDEN  in  1  read strobe
- RDATA  out  32  read data, registered
- FIFO_UNDER  in  1  pixel FIFO underflow pulse
- DSP_HSYNC  out  1  horizontal sync, active-low
- DSP_VSYNC  out  1  vertical sync, active-low
- DSP_DE  out  1  data enable (active pixel)
- FRAME_START  out  1  one-cycle pulse on the first cycle of each displayed frame
- DSP_ADDR  out  29  frame base address for the reader, stable for the whole frame
- DSP_ON  out  1  display running (effective, frame-aligned)
- DISP_IRQ  out  1  vblank interrupt, level

Behaviour:
- Reset (ARST=0 at a clock edge):
  - all registers and counters go to 0.
  - RDATA=0, DSP_HSYNC=1, DSP_VSYNC=1, DSP_DE=0, FRAME_START=0, DSP_ADDR=0, DSP_ON=0, DISP_IRQ=0.
- Registers. Writes require WREN and a matching WRADDR.
  - 0x2000 DISPADDR: byte-enabled write. Bits [31:29] always 0; bits [1:0] forced 0.
  - 0x2004 DISPCTRL:
    - bit0 DISP_ON (R/W, BYTEEN[0]).
    - bit1 VBLANK (set by hardware; cleared by writing 1 with BYTEEN[0]).
  - 0x2008 DISPINT:
    - bit0 INTENBL (R/W, BYTEEN[0]).
    - Writing 1 to bit1 with BYTEEN[0] clears DISP_IRQ. Bit1 reads the DISP_IRQ level.
  - 0x200C DISPFIFO: bit0 UNDER, sticky on FIFO_UNDER, write-1-to-clear with BYTEEN[0].
  - Read: RDATA is updated 1 cycle after RDEN. Unmapped addresses return 0xDEADFACE. With RDEN=0, RDATA holds its value.
- Timing counters:
  - HTOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; VTOTAL likewise.
  - hcnt runs 0..HTOTAL-1 and wraps to 0.
  - vcnt increments when hcnt wraps; vcnt runs 0..VTOTAL-1 and wraps to 0.
- Run/stop control:
  - DSP_ON goes 0→1 at the first cycle with DISP_ON=1. Counters then start from (0,0).
  - A 1→0 change of DISP_ON takes effect only at frame end (hcnt=HTOTAL-1, vcnt=VTOTAL-1). Frames are never truncated.
  - While DSP_ON=0: counters are held at 0, syncs are inactive, DE=0, no FRAME_START.
- Outputs, registered one cycle after the counter state:
  - DE = (hcnt<H_ACTIVE && vcnt<V_ACTIVE).
  - HSYNC low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - VSYNC low for vcnt in the equivalent V range, for whole lines.
  - FRAME_START=1 when the counters are at (0,0) with DSP_ON=1.
- Vblank event: the cycle where the counters are at (hcnt=0, vcnt=V_ACTIVE) with DSP_ON=1. On that cycle:
  - VBLANK is set.
  - DSP_ADDR is loaded from DISPADDR[28:0], so the next frame uses the new base.
  - DISP_IRQ is set if INTENBL=1.
- DSP_ADDR also loads from DISPADDR on the 0→1 transition of DSP_ON.
- Simultaneous set and clear on the same cycle: hardware set wins for VBLANK, DISP_IRQ and UNDER.
- Clearing INTENBL does not clear a pending DISP_IRQ.
- Reset mid-frame: everything returns to reset values on the next edge. The display restarts only after DISP_ON is written again.

Test Plan:
Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (HTOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (VTOTAL=7); frame = 98 clocks.
- Reset, then read 0x2000/0x2004/0x2008/0x200C/0x2010 → 0, 0, 0, 0, 0xDEADFACE, each 1 cycle after RDEN.
- Write DISPADDR=0xFFFF_FFFF, BYTEEN=0xF → reads 0x1FFF_FFFC.
- Write DISP_ON=1 → FRAME_START every 98 clocks.
  - DE high 8 clocks per line on 4 lines.
  - HSYNC low 2 clocks starting 10 clocks after line start.
  - VSYNC low for line 5 only.
- INTENBL=1, DISPADDR=0x100 during active video → at vcnt=4 VBLANK=1, DISP_IRQ=1, DSP_ADDR=0x100.
  - Write 0x2008 bit1 → IRQ=0.
  - Write 0x2004 bit1 on the same cycle as the next vblank event → VBLANK stays 1.
- Write DISP_ON=0 mid-frame → timing continues to the end of the frame, then DSP_ON=0, HSYNC=VSYNC=1, DE=0.
- Pulse FIFO_UNDER → 0x200C reads 1; write 1 → reads 0. ARST=0 mid-frame → all outputs at reset values on the next edge.
